// File: rtl/id_hazard_if.sv
// Bundle between the fetch/register-file side and the ID hazard stage.
// The master side drives the IF/ID and register-file signals; the slave side is the ID stage.
interface id_hazard_if;
  logic [31:0] IFIDInstr;
  logic [31:0] IFIDPCPlus4;
  logic [31:0] IFPCPlus4;
  logic [31:0] RsData;
  logic [31:0] RtData;

  logic [31:0] IDJumpTarget;
  logic [31:0] IDNonJumpTarget;
  logic        IDJump;
  logic        IFIDFlush;
  logic        IFIDWrite;
  logic        IFPCWrite;

  logic        IDEXRegWrite;
  logic        IDEXMemRead;
  logic        IDEXMemWrite;
  logic [4:0]  IDEXDest;
  logic [4:0]  IDEXRs;
  logic [4:0]  IDEXRt;
  logic [31:0] IDEXRsData;
  logic [31:0] IDEXRtData;
  logic [31:0] IDEXImm;
  logic [31:0] IDEXPCPlus4;
  logic [5:0]  IDEXOpcode;
  logic [5:0]  IDEXFunct;

  modport master (
    output IFIDInstr, IFIDPCPlus4, IFPCPlus4, RsData, RtData,
    input  IDJumpTarget, IDNonJumpTarget, IDJump, IFIDFlush, IFIDWrite, IFPCWrite,
    input  IDEXRegWrite, IDEXMemRead, IDEXMemWrite, IDEXDest, IDEXRs, IDEXRt,
    input  IDEXRsData, IDEXRtData, IDEXImm, IDEXPCPlus4, IDEXOpcode, IDEXFunct
  );

  modport slave (
    input  IFIDInstr, IFIDPCPlus4, IFPCPlus4, RsData, RtData,
    output IDJumpTarget, IDNonJumpTarget, IDJump, IFIDFlush, IFIDWrite, IFPCWrite,
    output IDEXRegWrite, IDEXMemRead, IDEXMemWrite, IDEXDest, IDEXRs, IDEXRt,
    output IDEXRsData, IDEXRtData, IDEXImm, IDEXPCPlus4, IDEXOpcode, IDEXFunct
  );
endinterface

// File: rtl/id_hazard_stage.sv
// ID stage: decode, jump/branch resolution, load-use and branch-operand stalls, ID/EX register.
// Optional macro ID_JR_EN makes R-type funct 0x08 (jr) a register-indirect jump.
module id_hazard_stage (
  input  logic       clock,
  input  logic       reset,
  id_hazard_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [31:0] imm_sext;

  assign instr    = bus.IFIDInstr;
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign imm16    = instr[15:0];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};

  logic is_rtype, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_imm_alu, is_jr;
  logic known_op;

  assign is_rtype   = (opcode == OP_RTYPE);
  assign is_j       = (opcode == OP_J);
  assign is_jal     = (opcode == OP_JAL);
  assign is_beq     = (opcode == OP_BEQ);
  assign is_bne     = (opcode == OP_BNE);
  assign is_lw      = (opcode == OP_LW);
  assign is_sw      = (opcode == OP_SW);
  assign is_imm_alu = (opcode == OP_ADDI) || (opcode == OP_SLTI) ||
                      (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign known_op   = is_rtype || is_j || is_jal || is_beq || is_bne ||
                      is_lw || is_sw || is_imm_alu;

`ifdef ID_JR_EN
  localparam logic [5:0] FN_JR = 6'h08;
  assign is_jr = is_rtype && (funct == FN_JR);
`else
  assign is_jr = 1'b0;
`endif

  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic [4:0] dec_dest;
  logic       use_rs;
  logic       use_rt;
  logic       ctl_hazard_insn;

  assign dec_reg_write = (is_rtype && !is_jr) || is_lw || is_imm_alu || is_jal;
  assign dec_mem_read  = is_lw;
  assign dec_mem_write = is_sw;

  always_comb begin
    dec_dest = 5'd0;
    if (dec_reg_write) begin
      if (is_rtype)    dec_dest = rd;
      else if (is_jal) dec_dest = 5'd31;
      else             dec_dest = rt;
    end
  end

  assign use_rs          = known_op && !is_j && !is_jal;
  assign use_rt          = (is_rtype && !is_jr) || is_sw || is_beq || is_bne;
  assign ctl_hazard_insn = is_beq || is_bne || is_jr;

  logic        idex_reg_write;
  logic        idex_mem_read;
  logic        idex_mem_write;
  logic [4:0]  idex_dest;
  logic [4:0]  idex_rs;
  logic [4:0]  idex_rt;
  logic [31:0] idex_rs_data;
  logic [31:0] idex_rt_data;
  logic [31:0] idex_imm;
  logic [31:0] idex_pc_plus4;
  logic [5:0]  idex_opcode;
  logic [5:0]  idex_funct;

  logic        exmem_reg_write;
  logic        exmem_mem_read;
  logic [4:0]  exmem_dest;

  // Branches compare in ID, so they must wait for any in-flight producer, not only loads.
  logic rs_hit_idex, rt_hit_idex, rs_hit_exmem, rt_hit_exmem;
  logic branch_stall, load_stall, stall;

  assign rs_hit_idex  = use_rs && (rs != 5'd0) && idex_reg_write  && (rs == idex_dest);
  assign rt_hit_idex  = use_rt && (rt != 5'd0) && idex_reg_write  && (rt == idex_dest);
  assign rs_hit_exmem = use_rs && (rs != 5'd0) && exmem_reg_write && (rs == exmem_dest);
  assign rt_hit_exmem = use_rt && (rt != 5'd0) && exmem_reg_write && (rt == exmem_dest);

  assign branch_stall = ctl_hazard_insn &&
                        (rs_hit_idex || rt_hit_idex || rs_hit_exmem || rt_hit_exmem);
  assign load_stall   = !ctl_hazard_insn && idex_mem_read && (idex_dest != 5'd0) &&
                        ((use_rs && (rs == idex_dest)) || (use_rt && (rt == idex_dest)));
  assign stall        = !reset && (branch_stall || load_stall);

  logic        operands_equal;
  logic        taken;
  logic        redirect;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign operands_equal = (bus.RsData == bus.RtData);
  assign taken          = is_j || is_jal || is_jr ||
                          (is_beq && operands_equal) || (is_bne && !operands_equal);
  assign redirect       = taken && !stall && !reset;

  assign branch_target  = bus.IFIDPCPlus4 + {imm_sext[29:0], 2'b00};

  always_comb begin
    jump_target = branch_target;
    if (is_j || is_jal) jump_target = {bus.IFIDPCPlus4[31:28], instr[25:0], 2'b00};
    else if (is_jr)     jump_target = bus.RsData;
  end

  assign bus.IDJumpTarget    = jump_target;
  assign bus.IDNonJumpTarget = bus.IFPCPlus4;
  assign bus.IDJump          = redirect;
  assign bus.IFIDFlush       = redirect;
  assign bus.IFIDWrite       = !stall;
  assign bus.IFPCWrite       = !stall;

  // A stall still advances the shadow EXMEM; only the ID/EX slot gets a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_dest       <= 5'd0;
      idex_rs         <= 5'd0;
      idex_rt         <= 5'd0;
      idex_rs_data    <= 32'd0;
      idex_rt_data    <= 32'd0;
      idex_imm        <= 32'd0;
      idex_pc_plus4   <= 32'd0;
      idex_opcode     <= 6'd0;
      idex_funct      <= 6'd0;
      exmem_reg_write <= 1'b0;
      exmem_mem_read  <= 1'b0;
      exmem_dest      <= 5'd0;
    end else begin
      exmem_reg_write <= idex_reg_write;
      exmem_mem_read  <= idex_mem_read;
      exmem_dest      <= idex_dest;
      if (stall) begin
        idex_reg_write <= 1'b0;
        idex_mem_read  <= 1'b0;
        idex_mem_write <= 1'b0;
        idex_dest      <= 5'd0;
        idex_rs        <= 5'd0;
        idex_rt        <= 5'd0;
        idex_rs_data   <= 32'd0;
        idex_rt_data   <= 32'd0;
        idex_imm       <= 32'd0;
        idex_pc_plus4  <= 32'd0;
        idex_opcode    <= 6'd0;
        idex_funct     <= 6'd0;
      end else begin
        idex_reg_write <= dec_reg_write;
        idex_mem_read  <= dec_mem_read;
        idex_mem_write <= dec_mem_write;
        idex_dest      <= dec_dest;
        idex_rs        <= rs;
        idex_rt        <= rt;
        idex_rs_data   <= bus.RsData;
        idex_rt_data   <= bus.RtData;
        idex_imm       <= imm_sext;
        idex_pc_plus4  <= bus.IFIDPCPlus4;
        idex_opcode    <= opcode;
        idex_funct     <= funct;
      end
    end
  end

  assign bus.IDEXRegWrite = idex_reg_write;
  assign bus.IDEXMemRead  = idex_mem_read;
  assign bus.IDEXMemWrite = idex_mem_write;
  assign bus.IDEXDest     = idex_dest;
  assign bus.IDEXRs       = idex_rs;
  assign bus.IDEXRt       = idex_rt;
  assign bus.IDEXRsData   = idex_rs_data;
  assign bus.IDEXRtData   = idex_rt_data;
  assign bus.IDEXImm      = idex_imm;
  assign bus.IDEXPCPlus4  = idex_pc_plus4;
  assign bus.IDEXOpcode   = idex_opcode;
  assign bus.IDEXFunct    = idex_funct;

  // The load flag in EXMEM is carried for the execute side; no ID hazard depends on it.
  logic unused_exmem;
  assign unused_exmem = exmem_mem_read;

endmodule

// File: tb/tb_id_hazard_stage.sv
// Self-checking bench for id_hazard_stage: directed scenarios plus random streams
// compared against a pipeline-occupancy reference model.
module tb_id_hazard_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  id_hazard_if bus();
  id_hazard_stage dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rw;
    logic        mr;
    logic        mw;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [5:0]  op;
    logic [5:0]  fn;
  } idex_t;

  // Model: what sits in ID/EX, and who (if anyone) writes a register one slot further on.
  idex_t      m_idex = '0;
  logic       m_ex_rw = 1'b0;
  logic [4:0] m_ex_dest = 5'd0;

  logic [31:0] cur_ins = 0, cur_pc4 = 0, cur_rsd = 0, cur_rtd = 0;

  function automatic idex_t ref_decode(input logic [31:0] ins, pc4, rsd, rtd);
    idex_t r;
    r = '0;
    r.op = ins[31:26]; r.fn = ins[5:0]; r.rs = ins[25:21]; r.rt = ins[20:16];
    r.rsd = rsd; r.rtd = rtd; r.pc4 = pc4;
    r.imm = {{16{ins[15]}}, ins[15:0]};
    case (ins[31:26])
      6'h00: begin
        r.rw = 1'b1; r.dest = ins[15:11];
`ifdef ID_JR_EN
        if (ins[5:0] == 6'h08) begin r.rw = 1'b0; r.dest = 5'd0; end
`endif
      end
      6'h23:                      begin r.rw = 1'b1; r.mr = 1'b1; r.dest = ins[20:16]; end
      6'h2B:                      r.mw = 1'b1;
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin r.rw = 1'b1; r.dest = ins[20:16]; end
      6'h03:                      begin r.rw = 1'b1; r.dest = 5'd31; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic is_jr_ref(input logic [31:0] ins);
`ifdef ID_JR_EN
    return (ins[31:26] == 6'h00) && (ins[5:0] == 6'h08);
`else
    return (ins == 32'hFFFF_FFFF);
`endif
  endfunction

  function automatic logic ref_stall(input logic [31:0] ins);
    logic [4:0] srcs[2];
    logic       used[2];
    logic       br;
    logic       hit;
    logic [5:0] op;
    op = ins[31:26];
    srcs[0] = ins[25:21]; srcs[1] = ins[20:16];
    used[0] = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
              (op == 6'h05) || (op == 6'h08) || (op == 6'h0A) || (op == 6'h0C) || (op == 6'h0D);
    used[1] = ((op == 6'h00) && !is_jr_ref(ins)) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
    br = (op == 6'h04) || (op == 6'h05) || is_jr_ref(ins);
    hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (used[i] && srcs[i] != 5'd0) begin
        if (br) begin
          if ((m_idex.rw && m_idex.dest == srcs[i]) || (m_ex_rw && m_ex_dest == srcs[i])) hit = 1'b1;
        end else if (m_idex.mr && m_idex.dest == srcs[i]) begin
          hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

  function automatic void ref_redirect(input logic [31:0] ins, pc4, rsd, rtd,
                                       output logic taken, output logic [31:0] tgt);
    logic [31:0] off;
    off = {{16{ins[15]}}, ins[15:0]};
    tgt = pc4 + off * 32'd4;
    taken = 1'b0;
    case (ins[31:26])
      6'h02, 6'h03: begin taken = 1'b1; tgt = {pc4[31:28], ins[25:0], 2'b00}; end
      6'h04: taken = (rsd == rtd);
      6'h05: taken = (rsd != rtd);
      default: if (is_jr_ref(ins)) begin taken = 1'b1; tgt = rsd; end
    endcase
  endfunction

  function automatic idex_t dut_idex();
    idex_t r;
    r.rw = bus.IDEXRegWrite; r.mr = bus.IDEXMemRead; r.mw = bus.IDEXMemWrite;
    r.dest = bus.IDEXDest; r.rs = bus.IDEXRs; r.rt = bus.IDEXRt;
    r.rsd = bus.IDEXRsData; r.rtd = bus.IDEXRtData; r.imm = bus.IDEXImm;
    r.pc4 = bus.IDEXPCPlus4; r.op = bus.IDEXOpcode; r.fn = bus.IDEXFunct;
    return r;
  endfunction

  task automatic drive(input logic rst, input logic [31:0] ins, pc4, ifpc4, rsd, rtd);
    @(negedge clock);
    reset = rst;
    cur_ins = ins; cur_pc4 = pc4; cur_rsd = rsd; cur_rtd = rtd;
    bus.IFIDInstr = ins; bus.IFIDPCPlus4 = pc4; bus.IFPCPlus4 = ifpc4;
    bus.RsData = rsd; bus.RtData = rtd;
    #1;
  endtask

  task automatic advance();
    logic st;
    @(posedge clock);
    if (reset) begin
      m_idex = '0; m_ex_rw = 1'b0; m_ex_dest = 5'd0;
    end else begin
      st = ref_stall(cur_ins);
      m_ex_rw = m_idex.rw; m_ex_dest = m_idex.dest;
      m_idex = st ? '0 : ref_decode(cur_ins, cur_pc4, cur_rsd, cur_rtd);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h0800_0010, 32'h0040_0004, 32'h0040_0008, 0, 0);
    checks += 4;
    if (bus.IDJump !== 1'b0)    begin errors++; $display("FAIL reset_idjump: got %b expected 0", bus.IDJump); end
    if (bus.IFIDFlush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", bus.IFIDFlush); end
    if (bus.IFIDWrite !== 1'b1) begin errors++; $display("FAIL reset_ifidwrite: got %b expected 1", bus.IFIDWrite); end
    if (bus.IFPCWrite !== 1'b1) begin errors++; $display("FAIL reset_pcwrite: got %b expected 1", bus.IFPCWrite); end
    advance();
    checks++;
    if (dut_idex() !== idex_t'(0)) begin errors++; $display("FAIL reset_idex: got %h expected 0", dut_idex()); end
  endtask

  task automatic test_jump();
    drive(1'b0, 32'h0800_0010, 32'h0040_0004, 32'h0040_0008, 0, 0);
    checks += 5;
    if (bus.IDJumpTarget !== 32'h0000_0040)    begin errors++; $display("FAIL j_target: got %h expected 00000040", bus.IDJumpTarget); end
    if (bus.IDJump !== 1'b1)                   begin errors++; $display("FAIL j_idjump: got %b expected 1", bus.IDJump); end
    if (bus.IFIDFlush !== 1'b1)                begin errors++; $display("FAIL j_flush: got %b expected 1", bus.IFIDFlush); end
    if (bus.IFPCWrite !== 1'b1)                begin errors++; $display("FAIL j_pcwrite: got %b expected 1", bus.IFPCWrite); end
    if (bus.IDNonJumpTarget !== 32'h0040_0008) begin errors++; $display("FAIL j_seq: got %h expected 00400008", bus.IDNonJumpTarget); end
    advance();
    checks++;
    if (dut_idex() !== m_idex) begin errors++; $display("FAIL j_idex: got %h expected %h", dut_idex(), m_idex); end
    drive(1'b0, 32'h0C00_0010, 32'h0040_0004, 32'h0040_0008, 0, 0);
    advance();
    checks += 3;
    if (bus.IDEXRegWrite !== 1'b1)          begin errors++; $display("FAIL jal_rw: got %b expected 1", bus.IDEXRegWrite); end
    if (bus.IDEXDest !== 5'd31)             begin errors++; $display("FAIL jal_dest: got %0d expected 31", bus.IDEXDest); end
    if (bus.IDEXPCPlus4 !== 32'h0040_0004)  begin errors++; $display("FAIL jal_link: got %h expected 00400004", bus.IDEXPCPlus4); end
  endtask

  task automatic test_branch();
    drive(1'b0, 32'h1022_0003, 32'h0000_0100, 32'h0000_0200, 5, 5);
    checks += 2;
    if (bus.IDJumpTarget !== 32'h0000_010C) begin errors++; $display("FAIL beq_target: got %h expected 0000010c", bus.IDJumpTarget); end
    if (bus.IDJump !== 1'b1)                begin errors++; $display("FAIL beq_taken: got %b expected 1", bus.IDJump); end
    advance();
    drive(1'b0, 32'h1022_0003, 32'h0000_0100, 32'h0000_0204, 5, 6);
    checks += 3;
    if (bus.IDJump !== 1'b0)                   begin errors++; $display("FAIL beq_nottaken: got %b expected 0", bus.IDJump); end
    if (bus.IFIDFlush !== 1'b0)                begin errors++; $display("FAIL beq_noflush: got %b expected 0", bus.IFIDFlush); end
    if (bus.IDNonJumpTarget !== 32'h0000_0204) begin errors++; $display("FAIL beq_seq: got %h expected 00000204", bus.IDNonJumpTarget); end
    advance();
  endtask

  task automatic test_load_use();
    drive(1'b0, 32'h8C23_0000, 32'h0000_0300, 32'h0000_0304, 0, 0);
    checks++;
    if (bus.IFPCWrite !== 1'b1) begin errors++; $display("FAIL lw_nostall: got %b expected 1", bus.IFPCWrite); end
    advance();
    drive(1'b0, 32'h0065_2020, 32'h0000_0304, 32'h0000_0308, 1, 2);
    checks += 3;
    if (bus.IFPCWrite !== 1'b0) begin errors++; $display("FAIL lu_pcwrite: got %b expected 0", bus.IFPCWrite); end
    if (bus.IFIDWrite !== 1'b0) begin errors++; $display("FAIL lu_ifidwrite: got %b expected 0", bus.IFIDWrite); end
    if (bus.IDJump !== 1'b0)    begin errors++; $display("FAIL lu_idjump: got %b expected 0", bus.IDJump); end
    advance();
    checks++;
    if (dut_idex() !== idex_t'(0)) begin errors++; $display("FAIL lu_bubble: got %h expected 0", dut_idex()); end
    drive(1'b0, 32'h0065_2020, 32'h0000_0304, 32'h0000_0308, 1, 2);
    checks++;
    if (bus.IFPCWrite !== 1'b1) begin errors++; $display("FAIL lu_release: got %b expected 1", bus.IFPCWrite); end
    advance();
    checks += 2;
    if (bus.IDEXDest !== 5'd4)     begin errors++; $display("FAIL lu_issue_dest: got %0d expected 4", bus.IDEXDest); end
    if (bus.IDEXRegWrite !== 1'b1) begin errors++; $display("FAIL lu_issue_rw: got %b expected 1", bus.IDEXRegWrite); end
  endtask

  task automatic test_branch_stall();
    int stalls;
    bit done;
    drive(1'b0, 32'h0043_0820, 32'h0000_0400, 32'h0000_0404, 0, 0);
    advance();
    stalls = 0;
    done = 0;
    for (int i = 0; i < 6 && !done; i++) begin
      drive(1'b0, 32'h1022_FFFF, 32'h0000_0000, 32'h0000_0004, 7, 7);
      if (bus.IFPCWrite === 1'b0) begin
        stalls++;
      end else begin
        done = 1;
        checks += 2;
        if (bus.IDJump !== 1'b1)                begin errors++; $display("FAIL bs_taken: got %b expected 1", bus.IDJump); end
        if (bus.IDJumpTarget !== 32'hFFFF_FFFC) begin errors++; $display("FAIL bs_target: got %h expected fffffffc", bus.IDJumpTarget); end
      end
      advance();
    end
    checks += 2;
    if (!done)       begin errors++; $display("FAIL bs_timeout: got unresolved expected resolved"); end
    if (stalls != 2) begin errors++; $display("FAIL bs_stall_count: got %0d expected 2", stalls); end
  endtask

  task automatic test_jr();
    drive(1'b0, 32'h03E0_0008, 32'h0000_0500, 32'h0000_0504, 32'h0040_0020, 0);
`ifdef ID_JR_EN
    checks += 2;
    if (bus.IDJump !== 1'b1)                begin errors++; $display("FAIL jr_taken: got %b expected 1", bus.IDJump); end
    if (bus.IDJumpTarget !== 32'h0040_0020) begin errors++; $display("FAIL jr_target: got %h expected 00400020", bus.IDJumpTarget); end
`else
    checks += 2;
    if (bus.IDJump !== 1'b0)    begin errors++; $display("FAIL jr_plain: got %b expected 0", bus.IDJump); end
    if (bus.IFIDFlush !== 1'b0) begin errors++; $display("FAIL jr_noflush: got %b expected 0", bus.IFIDFlush); end
`endif
    advance();
  endtask

  task automatic test_random();
    logic [5:0]  ops[11];
    logic [5:0]  fns[3];
    logic [31:0] ins, pc4, ifpc4, rsd, rtd, tgt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic        hold, rst, taken, exp_stall, exp_jump;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0A, 6'h0C, 6'h0D};
    fns = '{6'h20, 6'h22, 6'h08};
    hold = 1'b0;
    ins = 0; pc4 = 0;
    for (int c = 0; c < 500; c++) begin
      if (!hold) begin
        op = ops[$urandom_range(0, 10)];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        if (op == 6'h00)                     ins = {op, rs, rt, rd, 5'd0, fns[$urandom_range(0, 2)]};
        else if (op == 6'h02 || op == 6'h03) ins = {op, 26'($urandom)};
        else                                 ins = {op, rs, rt, 16'($urandom)};
        pc4 = $urandom;
      end
      rsd = 32'($urandom_range(0, 3));
      rtd = ($urandom_range(0, 1) == 1) ? rsd : $urandom;
      ifpc4 = $urandom;
      rst = ($urandom_range(0, 39) == 0);
      drive(rst, ins, pc4, ifpc4, rsd, rtd);
      exp_stall = !rst && ref_stall(ins);
      ref_redirect(ins, pc4, rsd, rtd, taken, tgt);
      exp_jump = !rst && !exp_stall && taken;
      checks += 6;
      if (bus.IFPCWrite !== !exp_stall) begin errors++; $display("FAIL rnd_pcwrite c%0d: got %b expected %b", c, bus.IFPCWrite, !exp_stall); end
      if (bus.IFIDWrite !== !exp_stall) begin errors++; $display("FAIL rnd_ifidwrite c%0d: got %b expected %b", c, bus.IFIDWrite, !exp_stall); end
      if (bus.IDJump !== exp_jump)      begin errors++; $display("FAIL rnd_idjump c%0d: got %b expected %b", c, bus.IDJump, exp_jump); end
      if (bus.IFIDFlush !== exp_jump)   begin errors++; $display("FAIL rnd_flush c%0d: got %b expected %b", c, bus.IFIDFlush, exp_jump); end
      if (bus.IDJumpTarget !== tgt)     begin errors++; $display("FAIL rnd_target c%0d: got %h expected %h", c, bus.IDJumpTarget, tgt); end
      if (bus.IDNonJumpTarget !== ifpc4) begin errors++; $display("FAIL rnd_seq c%0d: got %h expected %h", c, bus.IDNonJumpTarget, ifpc4); end
      hold = exp_stall;
      advance();
      checks++;
      if (dut_idex() !== m_idex) begin errors++; $display("FAIL rnd_idex c%0d: got %h expected %h", c, dut_idex(), m_idex); end
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
    advance();
  endtask

  initial begin
    bus.IFIDInstr = 0; bus.IFIDPCPlus4 = 0; bus.IFPCPlus4 = 0; bus.RsData = 0; bus.RtData = 0;
    test_reset();
    test_jump();
    test_branch();
    test_load_use();
    test_branch_stall();
    test_jr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_hazard_stage.md
# id_hazard_stage

Instruction-decode stage that consumes the IF/ID pipeline register, resolves jumps and branches in ID, and drives the fetch-stage controls (next-PC select, IF/ID flush, IF/ID write, PC write). It also owns the ID/EX pipeline register and a two-stage destination scoreboard, inserting load-use and branch-operand stalls. It sits between the fetch stage and the execute stage, alongside the register file.

## Interface
- No parameters; widths fixed at 32-bit data, 5-bit register index.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- IFIDInstr  in  32  instruction from IF/ID register
- IFIDPCPlus4  in  32  PC+4 of IFIDInstr
- IFPCPlus4  in  32  PC+4 of instruction currently in IF
- RsData, RtData  in  32  register-file read of rs/rt (write-before-read register file)
- IDJumpTarget  out  32  redirect target
- IDNonJumpTarget  out  32  sequential target, equal to IFPCPlus4
- IDJump  out  1  select IDJumpTarget as next PC
- IFIDFlush  out  1  zero IF/ID on next edge
- IFIDWrite  out  1  IF/ID load enable
- IFPCWrite  out  1  PC load enable
- IDEXRegWrite, IDEXMemRead, IDEXMemWrite  out  1 each  ID/EX control
- IDEXDest, IDEXRs, IDEXRt  out  5 each  destination and source indices
- IDEXRsData, IDEXRtData, IDEXImm, IDEXPCPlus4  out  32 each  operands, sign-extended immediate, link value
- IDEXOpcode  out  6; IDEXFunct  out  6  ALU decode passthrough

## Operation
- Decode: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03, addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D; other opcodes are no-ops (all control 0).
- RegWrite: R-type (dest rd), lw/addi/slti/andi/ori (dest rt), jal (dest 31). MemRead: lw. MemWrite: sw. Dest forced 0 when RegWrite=0.
- Rt is a source for R-type, sw, beq, bne; rs is a source for all except j/jal.
- Targets: j/jal = {IFIDPCPlus4[31:28], instr[25:0], 2'b00}; beq/bne = IFIDPCPlus4 + (signext(imm16) << 2), modulo 2^32. IDJumpTarget shows the branch target for every non-jump opcode.
- Taken: j, jal always; beq if RsData==RtData; bne if unequal.
- Scoreboard: shadow EXMEM {RegWrite, MemRead, Dest} loaded from ID/EX every cycle (downstream never stalls).
- Branch stall (beq/bne, and jr when enabled): any used source nonzero and equal to IDEXDest (IDEXRegWrite=1) or shadow EXMEM Dest (RegWrite=1).
- Load-use stall (all other instructions): IDEXMemRead=1, IDEXDest nonzero, equal to a used source.
- Stall: IFPCWrite=0, IFIDWrite=0, IDJump=0, IFIDFlush=0, ID/EX loaded with all-zero bubble.
- No stall, taken: IDJump=1, IFIDFlush=1, IFIDWrite=1, IFPCWrite=1; the jump instruction itself enters ID/EX (jal writes IFIDPCPlus4 to $31 via IDEXPCPlus4).
- No stall, not taken: IDJump=0, IFIDFlush=0, writes 1.
- Stall beats jump when both apply.

## Timing
- Fetch controls are combinational from IF/ID, RsData/RtData, and scoreboard; ID/EX and shadow EXMEM update at posedge clock.
- Taken redirect: one fetch-slot penalty (flushed slot becomes instr 0 = nop).
- Load-use: 1 stall cycle. Branch on ALU/lw result in ID/EX: 2 stall cycles; in shadow EXMEM: 1.
- Reset (checked at posedge): all ID/EX outputs and shadow EXMEM = 0. While reset=1: IDJump=0, IFIDFlush=0, IFIDWrite=1, IFPCWrite=1. Reset mid-stall cancels the stall on the following cycle.

## Configuration
- ID_JR_EN defined: R-type funct 0x08 (jr) is a jump; target RsData, rs is a branch-hazard source, RegWrite=0.
- Undefined: jr decodes as an ordinary R-type with no redirect.

## Test plan
- reset=1 one edge -> all IDEX* = 0, IFPCWrite=1, IFIDWrite=1, IDJump=0, IFIDFlush=0.
- IFIDInstr=0x08000010, IFIDPCPlus4=0x00400004 -> IDJumpTarget=0x00000040, IDJump=1, IFIDFlush=1.
- beq 0x10220003, IFIDPCPlus4=0x100, RsData=RtData=5 -> target 0x10C, IDJump=1; RtData=6 -> IDJump=0, IDNonJumpTarget=IFPCPlus4.
- lw $3,0($1) then add $4,$3,$5 -> one cycle IFPCWrite=0, IFIDWrite=0, IDEX bubble; add issues next cycle with IDEXDest=4.
- add $1,$2,$3 then beq $1,$2 -> exactly 2 stall cycles, then branch resolves; beq offset 0xFFFF, IFIDPCPlus4=0 -> target 0xFFFFFFFC.
- ID_JR_EN: jr $31 with RsData=0x00400020 -> IDJump=1, target 0x00400020; without macro -> IDJump=0.
